// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: 12-bit entries {FE, BE, OE, parity, data}, first-word-fall-through head,
// and overrun tracking that attaches OE to the next character actually stored.
module uart_rx_fifo #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              wr_en,
   input  logic [7:0]        rx_data,
   input  logic              rx_parity,
   input  logic              rx_break,
   input  logic              rx_frame,
   input  logic              rd_en,
   output logic [11:0]       data_out,
   output logic              empty,
   output logic              full,
   output logic [ADDR_W:0]   count,
   output logic              oe_pending
);

   typedef struct packed {
      logic       fe;
      logic       be;
      logic       oe;
      logic       par;
      logic [7:0] data;
   } rx_entry_t;

   localparam logic [ADDR_W:0] FULL_CNT = DEPTH[ADDR_W:0];

   rx_entry_t         mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic              wr_ok, rd_ok, overrun;
   rx_entry_t         wr_entry;

   assign empty = (count == '0);
   assign full  = (count == FULL_CNT);

   // A pop at full frees the slot the same cycle, so the write is still taken.
   assign wr_ok   = wr_en && (!full || rd_en);
   assign rd_ok   = rd_en && !empty;
   assign overrun = wr_en && full && !rd_en;

   assign wr_entry = '{fe: rx_frame, be: rx_break, oe: oe_pending,
                       par: rx_parity, data: rx_data};

   // Blank output when empty keeps the error detector from seeing a stale entry.
   assign data_out = empty ? 12'h000 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (wr_ok && !clr)
         mem[wr_ptr] <= wr_entry;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         oe_pending <= 1'b0;
      end else if (clr) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         oe_pending <= 1'b0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (wr_ok)        oe_pending <= 1'b0;
         else if (overrun) oe_pending <= 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: packing, wrap, overrun, simultaneous access, flush, async reset.
module tb_uart_rx_fifo;

   logic        clk = 1'b0;
   logic        rst, clr, wr_en, rx_parity, rx_break, rx_frame, rd_en;
   logic [7:0]  rx_data;
   logic [11:0] data_out;
   logic        empty, full, oe_pending;
   logic [4:0]  count;

   int n_chk = 0;
   int n_err = 0;

   uart_rx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
      .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .rx_data(rx_data),
      .rx_parity(rx_parity), .rx_break(rx_break), .rx_frame(rx_frame), .rd_en(rd_en),
      .data_out(data_out), .empty(empty), .full(full), .count(count), .oe_pending(oe_pending)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d, input logic p = 1'b0, input logic b = 1'b0,
                       input logic f = 1'b0);
      wr_en = 1'b1; rx_data = d; rx_parity = p; rx_break = b; rx_frame = f;
      tick();
      wr_en = 1'b0; rx_parity = 1'b0; rx_break = 1'b0; rx_frame = 1'b0;
   endtask

   task automatic pop();
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
   endtask

   task automatic pop_chk(input string tag, input logic [11:0] exp);
      chk(tag, data_out, exp);
      pop();
   endtask

   initial begin
      rst = 1'b0; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
      rx_data = 8'h00; rx_parity = 1'b0; rx_break = 1'b0; rx_frame = 1'b0;
      tick(); tick();
      chk("rst_empty", empty, 1);
      chk("rst_dout", data_out, 12'h000);
      rst = 1'b1;
      tick();
      chk("idle_empty", empty, 1);
      chk("idle_full", full, 0);
      chk("idle_count", count, 0);
      chk("idle_dout", data_out, 12'h000);
      chk("idle_oe", oe_pending, 0);

      // error packing
      push(8'hA5, 1'b1, 1'b0, 1'b1);
      chk("pack_dout", data_out, 12'h9A5);
      chk("pack_count", count, 1);
      pop();
      chk("pack_pop_dout", data_out, 12'h000);
      chk("pack_pop_empty", empty, 1);

      // pop on empty is ignored
      pop();
      chk("empty_pop_count", count, 0);

      // simultaneous on empty: write only, no bypass
      rd_en = 1'b1;
      push(8'h12);
      rd_en = 1'b0;
      chk("sim_empty_count", count, 1);
      chk("sim_empty_dout", data_out, 12'h012);
      // simultaneous non-empty non-full
      rd_en = 1'b1;
      push(8'h34);
      rd_en = 1'b0;
      chk("sim_mid_count", count, 1);
      chk("sim_mid_dout", data_out, 12'h034);
      pop();
      chk("sim_mid_empty", empty, 1);

      // fill and wrap
      for (int i = 0; i < 16; i++) push(8'(i));
      chk("fill_full", full, 1);
      chk("fill_count", count, 16);
      for (int i = 0; i < 8; i++) pop_chk("fill_pop", 12'(i));
      chk("half_count", count, 8);
      for (int i = 16; i < 24; i++) push(8'(i));
      chk("wrap_full", full, 1);
      chk("wrap_count", count, 16);

      // overrun
      push(8'h55);
      chk("ovr_oe1", oe_pending, 1);
      chk("ovr_count1", count, 16);
      push(8'h66);
      chk("ovr_oe2", oe_pending, 1);
      pop_chk("ovr_pop", 12'h008);
      push(8'h77);
      chk("ovr_oe_clr", oe_pending, 0);
      chk("ovr_count2", count, 16);

      // simultaneous at full
      chk("simf_head", data_out, 12'h009);
      rd_en = 1'b1;
      push(8'h3C);
      rd_en = 1'b0;
      chk("simf_count", count, 16);
      chk("simf_oe", oe_pending, 0);
      for (int i = 10; i < 24; i++) pop_chk("drain", 12'(i));
      pop_chk("drain_oe", 12'h277);
      pop_chk("drain_last", 12'h03C);
      chk("drain_empty", empty, 1);

      // flush with count=5 and oe pending
      for (int i = 0; i < 16; i++) push(8'h40 + 8'(i));
      push(8'h99);
      for (int i = 0; i < 11; i++) pop();
      chk("pre_clr_count", count, 5);
      chk("pre_clr_oe", oe_pending, 1);
      clr = 1'b1;
      push(8'hEE);
      clr = 1'b0;
      chk("clr_count", count, 0);
      chk("clr_empty", empty, 1);
      chk("clr_oe", oe_pending, 0);
      chk("clr_dout", data_out, 12'h000);
      push(8'h21);
      chk("post_clr_dout", data_out, 12'h021);
      pop();

      // asynchronous reset mid-operation
      push(8'h5A);
      push(8'h5B);
      chk("pre_arst_count", count, 2);
      #3 rst = 1'b0;
      #1;
      chk("arst_count", count, 0);
      chk("arst_empty", empty, 1);
      chk("arst_dout", data_out, 12'h000);
      tick();
      rst = 1'b1;
      tick();
      chk("arst_rel_empty", empty, 1);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
